// File: rtl/demux_8_fill.sv
// Write-side byte demultiplexer: steers a valid/ready byte stream into four
// registered slots A..D, tracks per-slot valid flags and holds off when full.
module demux_8_fill #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Din,
  input  logic [1:0]       Sel,
  input  logic             mode,
  input  logic             wr_valid,
  output logic             wr_ready,
  // Reader's release pulse; "release" itself is a reserved word in SystemVerilog.
  input  logic             rd_release,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [3:0]       slot_valid,
  output logic             full,
  output logic [1:0]       ptr
);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [WIDTH-1:0] slot_q [4];
  logic [WIDTH-1:0] slot_d [4];
  logic [3:0]       valid_q, valid_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             full_q, full_d;
  logic [1:0]       state_d;
  logic [1:0]       target;
  logic             accept;

  always_comb begin
    wr_ready = !full_q && !rd_release;
    accept   = wr_valid && wr_ready;
    target   = mode ? ptr_q : Sel;

    for (int i = 0; i < 4; i++) begin
      slot_d[i] = slot_q[i];
    end
    valid_d = valid_q;
    ptr_d   = ptr_q;

    // Release wins over a simultaneous write; slot data is kept for the reader.
    if (rd_release) begin
      valid_d = 4'b0000;
      ptr_d   = 2'd0;
    end else if (accept) begin
      slot_d[target]  = Din;
      valid_d[target] = 1'b1;
      if (mode) begin
        ptr_d = ptr_q + 2'd1;
      end
    end

    if (valid_d == 4'b0000) begin
      state_d = ST_EMPTY;
    end else if (valid_d == 4'b1111) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_FILLING;
    end
    full_d = (state_d == ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= '0;
      end
      valid_q <= 4'b0000;
      ptr_q   <= 2'd0;
      full_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= slot_d[i];
      end
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      full_q  <= full_d;
    end
  end

  assign A          = slot_q[0];
  assign B          = slot_q[1];
  assign C          = slot_q[2];
  assign D          = slot_q[3];
  assign slot_valid = valid_q;
  assign full       = full_q;
  assign ptr        = ptr_q;

endmodule
